alu_ctrl_fsm: RTL
=================

// Module: alu_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM that drives the ALU datapath and consumes its flags.
//  Accepts one 16-bit instruction per s pulse, reads operands from the register file
//  into the A/B latches, drives ALUop/shift/asel/bsel and writes back the C latch.
//  Holds the Z/N/V status register, which is loaded only by CMP.
//  Sits between the instruction source and the register-file/shifter/ALU datapath.
// PARAMETERS
//  WORD  16  datapath and instruction width (fixed; sximm8 is sign-extended to WORD)
// PORTS
//  clk      in   1   single clock, rising edge
//  reset    in   1   synchronous, active-high
//  s        in   1   start; sampled only in WAIT
//  instr    in   16  instruction; captured into IR when s is accepted
//  alu_z    in   1   ALU zero flag (combinational from A/B latches)
//  alu_n    in   1   ALU negative flag
//  alu_v    in   1   ALU overflow flag
//  w        out  1   idle/ready: 1 only in WAIT
//  rnum     out  3   register-file read/write index
//  write    out  1   register-file write enable
//  vsel     out  1   writeback source: 0 = C latch, 1 = sximm8
//  loada    out  1   load A latch
//  loadb    out  1   load B latch
//  loadc    out  1   load C latch
//  asel     out  1   1 forces ALU A input to 0
//  bsel     out  1   1 selects sximm8 for B (always 0 here; reserved)
//  ALUop    out  2   00 add, 01 sub, 10 and, 11 not-B
//  shift    out  2   shifter control = IR[4:3]
//  sximm8   out  16  {{8{IR[7]}}, IR[7:0]}
//  Z, N, V  out  1   registered status flags
//  err      out  1   1 for the DECODE cycle of an unrecognised instruction
// BEHAVIOUR
//  Reset: state WAIT, IR=0, Z=N=V=0. Strobes write/loada/loadb/loadc/asel/bsel and err are 0.
//  Reset mid-operation aborts the instruction: no write, no status update.
//  IR fields: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0].
//  Strobes are Moore outputs of the state and are 0 unless listed for that state.
//  WAIT:   w=1. If s=1, IR<=instr and go to DECODE. s in any other state is ignored.
//  DECODE: {110,10} MOV imm -> WIMM; {110,00} MOV reg -> GETB;
//          {101,11} MVN -> GETB; {101,00|01|10} ADD/CMP/AND -> GETA.
//          Any other encoding: err=1, then WAIT.
//  GETA:   rnum=Rn, loada=1, then GETB.
//  GETB:   rnum=Rm, loadb=1, then EXEC.
//  EXEC:   shift=sh, bsel=0.
//          MOV reg: asel=1, ALUop=00. Others: ALUop=op.
//          CMP: loads, i.e. {Z,N,V}<={alu_z,alu_n,alu_v} at this edge, then WAIT.
//          Others: loadc=1, then WREG.
//  WREG:   rnum=Rd, write=1, vsel=0, then WAIT.
//  WIMM:   rnum=Rn, write=1, vsel=1, then WAIT.
//  Latency from the s-accept edge to w=1: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6.
//  Z/N/V hold their value across every instruction except CMP.
//  sximm8 and shift are driven from IR in every state. Outside the listed states they are don't-care.
// STRUCTURE
//  srm_pkg: opcode/op constants, state enum (WAIT, DECODE, GETA, GETB, EXEC, WREG, WIMM),
//    VSEL_C/VSEL_IMM, ALUOP_* encodings.
//  Sub-module instr_decode: combinational IR field split, sximm8 extension and class decode.
//  FSM, IR and status register live in alu_ctrl_fsm.
// TESTING
//  1 reset; s=1, instr=0xD0FB (MOV R0,#-5) -> +2 cyc write=1 rnum=0 vsel=1 sximm8=0xFFFB; +3 w=1
//  2 instr=0xA148 (ADD R2,R1,R0,LSL#1) -> loada rnum=1; loadb rnum=0; EXEC ALUop=00 shift=01 loadc;
//    WREG rnum=2 write=1 vsel=0; w=1 at +6
//  3 instr=0xA900 (CMP R1,R0), in EXEC alu_z=0 alu_n=1 alu_v=1 -> next cycle Z=0 N=1 V=1;
//    write never asserted; later ADD leaves Z/N/V unchanged
//  4 instr=0xB864 (MVN R3,R4) -> loada never 1; loadb rnum=4; ALUop=11; write rnum=3
//  5 instr=0xE000 (opcode 111) -> err=1 for one cycle, no strobes, w=1 at +2
//  6 reset=1 during EXEC of 0xA148 with s held high -> next cycle WAIT, w=1, no write, Z=N=V=0;
//    s pulses while busy never restart the FSM

Source files
------------

// File: rtl/srm_pkg.sv
// srm_pkg: shared encodings, state enum and instruction classes for the ALU control FSM
package srm_pkg;
  localparam int WORD = 16;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic VSEL_C = 1'b0;
  localparam logic VSEL_IMM = 1'b1;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_AND = 2'b10;
  localparam logic [1:0] ALUOP_NOT = 2'b11;
  typedef enum logic [2:0] {WAIT, DECODE, GETA, GETB, EXEC, WREG, WIMM} state_t;
  typedef enum logic [2:0] {C_MOVI, C_MOVR, C_MVN, C_ALU, C_BAD} cls_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: splits IR into fields, sign-extends imm8 and classifies the instruction
module instr_decode
  import srm_pkg::*;
(
  input  logic [WORD-1:0] ir,
  output logic [2:0]      rn,
  output logic [2:0]      rd,
  output logic [2:0]      rm,
  output logic [1:0]      op,
  output logic [1:0]      sh,
  output logic [WORD-1:0] sximm8,
  output cls_t            cls
);
  logic [2:0] opc;
  assign opc = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  always_comb begin
    cls = (opc == OPC_MOV && op == OP_MOVI) ? C_MOVI :
          (opc == OPC_MOV && op == OP_MOVR) ? C_MOVR :
          (opc == OPC_ALU && op == OP_MVN)  ? C_MVN  :
          (opc == OPC_ALU)                  ? C_ALU  : C_BAD;
  end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle controller sequencing register-file/ALU datapath per instruction
module alu_ctrl_fsm
  import srm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            s,
  input  logic [WORD-1:0] instr,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_v,
  output logic            w,
  output logic [2:0]      rnum,
  output logic            write,
  output logic            vsel,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            asel,
  output logic            bsel,
  output logic [1:0]      ALUop,
  output logic [1:0]      shift,
  output logic [WORD-1:0] sximm8,
  output logic            Z,
  output logic            N,
  output logic            V,
  output logic            err
);
  state_t state, nxt;
  cls_t cls;
  logic [WORD-1:0] ir;
  logic [2:0] rn, rd, rm;
  logic [1:0] op, sh;
  logic is_cmp;
  instr_decode u_dec (
    .ir(ir), .rn(rn), .rd(rd), .rm(rm), .op(op), .sh(sh), .sximm8(sximm8), .cls(cls)
  );
  assign is_cmp = (cls == C_ALU) && (op == OP_CMP);
  assign shift = sh;
  assign bsel = 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir <= '0;
      {Z, N, V} <= 3'b000;
    end else begin
      state <= nxt;
      if (state == WAIT && s) ir <= instr;
      if (state == EXEC && is_cmp) {Z, N, V} <= {alu_z, alu_n, alu_v};
    end
  end
  always_comb begin
    nxt = state;
    w = 1'b0;
    rnum = rn;
    write = 1'b0;
    vsel = VSEL_C;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    asel = 1'b0;
    ALUop = ALUOP_ADD;
    err = 1'b0;
    case (state)
      WAIT: begin
        w = 1'b1;
        nxt = s ? DECODE : WAIT;
      end
      DECODE: begin
        err = (cls == C_BAD);
        nxt = (cls == C_MOVI) ? WIMM :
              (cls == C_MOVR || cls == C_MVN) ? GETB :
              (cls == C_ALU) ? GETA : WAIT;
      end
      GETA: begin
        loada = 1'b1;
        nxt = GETB;
      end
      GETB: begin
        rnum = rm;
        loadb = 1'b1;
        nxt = EXEC;
      end
      EXEC: begin
        asel = (cls == C_MOVR);
        ALUop = (cls == C_MOVR) ? ALUOP_ADD : op;
        loadc = !is_cmp;
        nxt = is_cmp ? WAIT : WREG;
      end
      WREG: begin
        rnum = rd;
        write = 1'b1;
        nxt = WAIT;
      end
      WIMM: begin
        write = 1'b1;
        vsel = VSEL_IMM;
        nxt = WAIT;
      end
      default: nxt = WAIT;
    endcase
  end
endmodule
